pin_input_filter: RTL and testbench
===================================

# pin_input_filter

Synchronises and glitch-filters every board input pin before it reaches the pinmux, covering the dedicated input pins and the input side of the bidirectional pins. Each pin gets a two-flop synchroniser and a per-pin persistence counter. The optional edge detector produces one-cycle rise/fall pulses for GPIO interrupt logic. The block sits between the top-level pad buffers and the pinmux input crossbar, in the system clock domain.

## Interface
Parameters:
- `NumPins`, default 78: pins handled, equal to input pin count (8) plus inout pin count (70). Input pins occupy indices 0..7 and inout pins occupy 8..77, in package order.
- `CntWidth`, default 4: width of each persistence counter and of the threshold.
- `ResetVal`, default all ones (`NumPins` bits): reset/idle level per pin. UART RX and I2C idle high.

Ports:
- `clk_i`, input, 1: system clock.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `pins_i`, input, `NumPins`: raw asynchronous pad inputs.
- `filter_en_i`, input, `NumPins`: per-pin filter enable. Quasi-static.
- `filter_thresh_i`, input, `CntWidth`: global persistence threshold T.
- `pins_o`, output, `NumPins`: synchronised, filtered pin levels.
- `rise_o`, output, `NumPins`: one-cycle rising-edge pulse of `pins_o`.
- `fall_o`, output, `NumPins`: one-cycle falling-edge pulse of `pins_o`.

## Operation
- Synchroniser: `s1 <= pins_i`; `s2 <= s1`. Both registers reset to `ResetVal`.
- Filter, per pin i, evaluated every cycle:
  - Filter disabled (`filter_en_i[i]`=0): `filt[i] <= s2[i]`; `cnt[i] <= 0`.
  - Filter enabled and `s2[i] == filt[i]`: `cnt[i] <= 0`.
  - Filter enabled, `s2[i] != filt[i]`, and `cnt[i] >= T`: `filt[i] <= s2[i]`; `cnt[i] <= 0`.
  - Filter enabled, `s2[i] != filt[i]`, and `cnt[i] < T`: `cnt[i] <= cnt[i] + 1`. The counter never wraps, because it stops at T.
  - Net effect: a new level must persist on `s2` for T+1 consecutive cycles before it is accepted. Any return to the old level, even for one cycle, restarts the count.
- `pins_o = filt`, which is a registered output.
- Edge detection: `filt_q <= filt`, with reset value `ResetVal`.
  - `rise_o = filt & ~filt_q`.
  - `fall_o = ~filt & filt_q`.
  - Each pulse is high for exactly the first cycle in which `pins_o` shows the new level.
- Threshold change: the new T applies from the next compare. If T is lowered below the current `cnt`, the `>=` test accepts the level on the next differing cycle.
- Enable toggled mid-count:
  - Disabling clears `cnt` and makes `filt` track `s2` on the next edge.
  - Re-enabling starts counting from 0.
- All pins are independent, and there is no cross-pin arbitration.

## Timing
- Reset values: `pins_o = ResetVal`; `rise_o = 0`; `fall_o = 0`; all `cnt = 0`. No edge pulse is generated by reset release when pads equal `ResetVal`.
- Latency, measured from the first clock edge that samples a new stable `pins_i`:
  - Filter disabled: `pins_o` updates after 3 edges.
  - Filter enabled: `pins_o` updates after 3+T edges.
- `rise_o`/`fall_o` assert in the same cycle that `pins_o` first changes.
- A glitch lasting k cycles on `s2` is rejected when k <= T.
- Reset asserted mid-count: on the next edge every register returns to its reset value, and the pending level change is discarded.
- Pin 0 and pin `NumPins-1` behave identically to the others.

## Configuration
- Macro: `PIN_INPUT_FILTER_EDGE_EN`.
- Defined: `filt_q` and the edge logic are built, and `rise_o`/`fall_o` behave as specified above.
- Undefined: `filt_q` is not instantiated, and `rise_o`/`fall_o` are tied to 0. Port list, `pins_o` behaviour and latency are unchanged.

## Test plan
- Reset and defaults:
  - Stimulus: hold `rst_i`=1 for 2 cycles with `pins_i`=all ones, then release.
  - Required: `pins_o`=all ones, `rise_o`=0 and `fall_o`=0 throughout, with no pulse after release.
- Bypass latency:
  - Stimulus: `filter_en_i`=0, drive pin 0 from 1 to 0.
  - Required: `pins_o[0]`=0 on the 3rd edge. `fall_o[0]` is high for exactly that cycle when the macro is defined, and 0 when it is not.
- Filter threshold:
  - Stimulus: `filter_en_i`=all ones, T=5, drive pin 77 from 1 to 0 and hold.
  - Required: `pins_o[77]` falls on edge 8, not earlier.
- Glitch rejection:
  - Stimulus: T=3, drive pin 10 low for 3 cycles, then high, then low for 4 cycles.
  - Required: no change on the 3-cycle pulse. `pins_o[10]` falls on edge 3+3 of the 4-cycle pulse and rises again after 6 cycles of high.
- Threshold lowered mid-count:
  - Stimulus: T=10, hold pin 20 low until `cnt`=6, then set T=2.
  - Required: `pins_o[20]` falls on the next edge.
- Reset mid-count:
  - Stimulus: T=8, assert `rst_i` for 1 cycle while pin 5 is 4 cycles into a low level.
  - Required: `pins_o[5]`=1 with no fall pulse. After release the count restarts, and the fall occurs 3+8 edges after release.

Source files
------------

// File: rtl/pin_input_filter.sv
// Two-flop synchroniser plus per-pin persistence filter for all board input pins.
// Optional rise/fall pulse generation is built when PIN_INPUT_FILTER_EDGE_EN is defined.
module pin_input_filter #(
  parameter int                 NumPins  = 78,
  parameter int                 CntWidth = 4,
  parameter logic [NumPins-1:0] ResetVal = {NumPins{1'b1}}
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPins-1:0]  pins_i,
  input  logic [NumPins-1:0]  filter_en_i,
  input  logic [CntWidth-1:0] filter_thresh_i,
  output logic [NumPins-1:0]  pins_o,
  output logic [NumPins-1:0]  rise_o,
  output logic [NumPins-1:0]  fall_o
);

  logic [NumPins-1:0]  sync1;
  logic [NumPins-1:0]  sync2;
  logic [NumPins-1:0]  filt;
  logic [CntWidth-1:0] cnt [NumPins];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= ResetVal;
      sync2 <= ResetVal;
    end else begin
      sync1 <= pins_i;
      sync2 <= sync1;
    end
  end

  // A differing level is accepted only once the count has reached the threshold,
  // so the counter saturates at T and can never wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt <= ResetVal;
      for (int i = 0; i < NumPins; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NumPins; i++) begin
        if (!filter_en_i[i]) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= filter_thresh_i) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CntWidth'(1);
        end
      end
    end
  end

  assign pins_o = filt;

`ifdef PIN_INPUT_FILTER_EDGE_EN
  logic [NumPins-1:0] filt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) filt_q <= ResetVal;
    else       filt_q <= filt;
  end

  assign rise_o = filt & ~filt_q;
  assign fall_o = ~filt & filt_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

// File: tb/tb_pin_input_filter.sv
// Self-checking bench for pin_input_filter: vector table, directed corner sequences
// and randomized traffic checked against a run-length reference model.
module tb_pin_input_filter;

  localparam int N = 78;
  localparam logic [N-1:0] RV = {N{1'b1}};
`ifdef PIN_INPUT_FILTER_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pins = RV;
  logic [N-1:0] en = RV;
  logic [3:0]   thr = 4'd0;
  logic [N-1:0] pins_out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  int n_cmp = 0;
  int n_bad = 0;

  pin_input_filter #(.NumPins(N), .CntWidth(4), .ResetVal(RV)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pins_i         (pins),
    .filter_en_i    (en),
    .filter_thresh_i(thr),
    .pins_o         (pins_out),
    .rise_o         (rise),
    .fall_o         (fall)
  );

  always #5 clk = ~clk;

  // Reference model: pad samples travel through a two-entry delay queue; each pin
  // remembers how many consecutive prior cycles the delayed sample disagreed with
  // the accepted level, and accepts the new level once that streak reaches T.
  logic [N-1:0] hist [$];
  logic [N-1:0] m_acc;
  logic [N-1:0] m_prev;
  int           streak [N];

  task automatic model_edge();
    logic [N-1:0] late;
    if (rst) begin
      hist = {RV, RV};
      m_acc = RV;
      m_prev = RV;
      for (int i = 0; i < N; i++) streak[i] = 0;
      return;
    end
    late = hist.pop_front();
    hist.push_back(pins);
    m_prev = m_acc;
    for (int i = 0; i < N; i++) begin
      if (!en[i] || late[i] == m_acc[i]) begin
        m_acc[i] = late[i];
        streak[i] = 0;
      end else if (streak[i] >= int'(thr)) begin
        m_acc[i] = late[i];
        streak[i] = 0;
      end else begin
        streak[i]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_output(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input int e, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s edge %0d: got %b want %b", name, e, got, exp);
    end
  endtask

  task automatic do_reset();
    pins = RV;
    en = RV;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] pins;
    logic [N-1:0] en;
    logic [N-1:0] exp_pins;
    logic [N-1:0] exp_rise;
    logic [N-1:0] exp_fall;
  } vec_t;

  vec_t vecs [12];

  task automatic apply_stimulus(input vec_t v);
    rst  = v.rst;
    pins = v.pins;
    en   = v.en;
    tick();
  endtask

  initial begin
    logic [N-1:0] p0low;
    logic [N-1:0] bit0;
    logic [N-1:0] none;
    logic [95:0]  rnd;
    p0low = RV;
    p0low[0] = 1'b0;
    bit0 = '0;
    bit0[0] = 1'b1;
    none = '0;

    // Reset, quiet release, then pin 0 through the bypass path in both directions.
    vecs[0]  = '{1'b1, RV,    RV,   RV,    none, none};
    vecs[1]  = '{1'b1, RV,    RV,   RV,    none, none};
    vecs[2]  = '{1'b0, RV,    RV,   RV,    none, none};
    vecs[3]  = '{1'b0, RV,    RV,   RV,    none, none};
    vecs[4]  = '{1'b0, RV,    RV,   RV,    none, none};
    vecs[5]  = '{1'b0, p0low, none, RV,    none, none};
    vecs[6]  = '{1'b0, p0low, none, RV,    none, none};
    vecs[7]  = '{1'b0, p0low, none, p0low, none, EdgeEn ? bit0 : none};
    vecs[8]  = '{1'b0, p0low, none, p0low, none, none};
    vecs[9]  = '{1'b0, RV,    none, p0low, none, none};
    vecs[10] = '{1'b0, RV,    none, p0low, none, none};
    vecs[11] = '{1'b0, RV,    none, RV,    EdgeEn ? bit0 : none, none};

    for (int k = 0; k < 12; k++) begin
      apply_stimulus(vecs[k]);
      check_output($sformatf("vec%0d_pins", k), pins_out, vecs[k].exp_pins);
      check_output($sformatf("vec%0d_rise", k), rise, vecs[k].exp_rise);
      check_output($sformatf("vec%0d_fall", k), fall, vecs[k].exp_fall);
    end

    // Pin 77, T=5: the fall must land on edge 8 and no earlier.
    do_reset();
    thr = 4'd5;
    pins[77] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check_bit("thresh_pin77", e, pins_out[77], e < 8);
      check_bit("thresh_fall77", e, fall[77], EdgeEn && e == 8);
    end

    // Pin 10, T=3: a 3-cycle low glitch is ignored, a 4-cycle low is accepted.
    do_reset();
    thr = 4'd3;
    pins[10] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      if (e == 4) pins[10] = 1'b1;
      tick();
      check_bit("glitch3_pin10", e, pins_out[10], 1'b1);
    end
    pins[10] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 5) pins[10] = 1'b1;
      tick();
      check_bit("glitch4_pin10", e, pins_out[10], !(e >= 6 && e <= 9));
      check_bit("glitch4_fall10", e, fall[10], EdgeEn && e == 6);
      check_bit("glitch4_rise10", e, rise[10], EdgeEn && e == 10);
    end

    // Pin 20: lowering T below the running count accepts on the next edge.
    do_reset();
    thr = 4'd10;
    pins[20] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      if (e == 9) thr = 4'd2;
      tick();
      check_bit("thrlow_pin20", e, pins_out[20], e < 9);
    end

    // Pin 5: reset mid-count discards progress; the fall comes 3+8 edges after release.
    do_reset();
    thr = 4'd8;
    pins[5] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_bit("rstmid_pin5", 0, pins_out[5], 1'b1);
    check_bit("rstmid_fall5", 0, fall[5], 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check_bit("rstmid_after_pin5", e, pins_out[5], e < 11);
      check_bit("rstmid_after_fall5", e, fall[5], EdgeEn && e == 11);
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) thr = 4'($urandom_range(0, 6));
      if (c % 150 == 0) begin
        rnd = {$urandom, $urandom, $urandom};
        en = rnd[N-1:0] | (c == 0 ? RV : '0);
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) pins[i] = ~pins[i];
      rst = ($urandom_range(0, 199) == 0);
      tick();
      check_output("rand_pins", pins_out, m_acc);
      check_output("rand_rise", rise, EdgeEn ? (m_acc & ~m_prev) : '0);
      check_output("rand_fall", fall, EdgeEn ? (~m_acc & m_prev) : '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
